// File: rtl/mest_pro_pkg.sv
// Shared types and constants for the MEST Pro core and its program memory.
package mest_pro_pkg;

  localparam int unsigned OP_W    = 4;
  localparam int unsigned INSTR_W = OP_W + 8 + 8 + 8;

  // END-of-code opcode; a word carrying it with zero operands halts the core.
  localparam logic [OP_W-1:0]    END_OPCODE = OP_W'(4'hF);
  localparam logic [INSTR_W-1:0] END_WORD   = {END_OPCODE, (INSTR_W - OP_W)'(0)};

  typedef enum logic [1:0] {
    IMEM_EMPTY = 2'd0,
    IMEM_LOAD  = 2'd1,
    IMEM_READY = 2'd2
  } imem_state_t;

endpackage

// File: rtl/mest_pro_imem_ram.sv
// Simple dual-port program RAM: one write port, one enabled registered read port, no reset.
module mest_pro_imem_ram #(
  parameter int unsigned WIDTH = 28,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register only moves on an enabled read so the last word is held.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mest_pro_imem.sv
// Program memory responder for the MEST Pro fetch port: host loads words over
// valid/ready, the core then fetches by PC with a fixed one-cycle latency.
module mest_pro_imem
  import mest_pro_pkg::*;
#(
  parameter int unsigned OP_CODE_SIZE     = 4,
  parameter int unsigned INSTRUCTION_SIZE = OP_CODE_SIZE + 8 + 8 + 8,
  parameter int unsigned ROM_DEPTH        = 16,
  parameter logic [INSTRUCTION_SIZE-1:0] FILL_WORD = INSTRUCTION_SIZE'(END_WORD),
  localparam int unsigned AW = $clog2(ROM_DEPTH),
  localparam int unsigned LW = AW + 1
) (
  input  logic                        clk,
  input  logic                        i_reset_n,
  input  logic                        i_load_start,
  input  logic                        i_load_valid,
  input  logic [INSTRUCTION_SIZE-1:0] i_load_data,
  input  logic                        i_load_last,
  output logic                        o_load_ready,
  output logic                        o_prog_ready,
  output logic [LW-1:0]               o_prog_len,
  input  logic                        i_req,
  input  logic [AW-1:0]               i_prog_counter,
  output logic [INSTRUCTION_SIZE-1:0] o_instruction,
  output logic                        o_instr_valid,
  output logic                        o_fetch_err
);

  imem_state_t state, state_next;
  logic [AW-1:0]               wr_ptr;
  logic                        load_go;
  logic                        accept;
  logic                        hit;
  logic                        sel_ram;
  logic [INSTRUCTION_SIZE-1:0] ram_rd_data;

  assign o_load_ready = (state == IMEM_LOAD);
  assign hit = (state == IMEM_READY) && (LW'(i_prog_counter) < o_prog_len);

  // Next state; a start pulse always wins over a word offered the same cycle.
  always_comb begin
    state_next = state;
    load_go    = 1'b0;
    accept     = 1'b0;
    case (state)
      IMEM_EMPTY: begin
        if (i_load_start) begin
          state_next = IMEM_LOAD;
          load_go    = 1'b1;
        end
      end
      IMEM_LOAD: begin
        if (i_load_start) begin
          state_next = IMEM_LOAD;
          load_go    = 1'b1;
        end else if (i_load_valid) begin
          accept = 1'b1;
          if (i_load_last || (wr_ptr == AW'(ROM_DEPTH - 1))) state_next = IMEM_READY;
        end
      end
      IMEM_READY: begin
        if (i_load_start) begin
          state_next = IMEM_LOAD;
          load_go    = 1'b1;
        end
      end
      default: state_next = IMEM_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= IMEM_EMPTY;
      wr_ptr       <= '0;
      o_prog_len   <= '0;
      o_prog_ready <= 1'b0;
    end else begin
      state        <= state_next;
      o_prog_ready <= (state_next == IMEM_READY);
      if (load_go) begin
        wr_ptr     <= '0;
        o_prog_len <= '0;
      end else if (accept) begin
        wr_ptr     <= wr_ptr + AW'(1);
        o_prog_len <= o_prog_len + LW'(1);
      end
    end
  end

  // Fetch response flags; sel_ram picks RAM data vs FILL_WORD and holds with the data.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_instr_valid <= 1'b0;
      o_fetch_err   <= 1'b0;
      sel_ram       <= 1'b0;
    end else begin
      o_instr_valid <= i_req;
      o_fetch_err   <= i_req && !hit;
      if (i_req) sel_ram <= hit;
    end
  end

  assign o_instruction = sel_ram ? ram_rd_data : FILL_WORD;

  mest_pro_imem_ram #(
    .WIDTH (INSTRUCTION_SIZE),
    .DEPTH (ROM_DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (wr_ptr),
    .wr_data (i_load_data),
    .rd_en   (i_req && hit),
    .rd_addr (i_prog_counter),
    .rd_data (ram_rd_data)
  );

endmodule

// File: tb/tb_mest_pro_imem.sv
// Directed bench for mest_pro_imem: load, fetch, range, restart and reset cases.
module tb_mest_pro_imem;

  localparam logic [27:0] FILL = 28'hF000000;

  logic        clk = 1'b0;
  logic        i_reset_n;
  logic        i_load_start;
  logic        i_load_valid;
  logic [27:0] i_load_data;
  logic        i_load_last;
  logic        o_load_ready;
  logic        o_prog_ready;
  logic [4:0]  o_prog_len;
  logic        i_req;
  logic [3:0]  i_prog_counter;
  logic [27:0] o_instruction;
  logic        o_instr_valid;
  logic        o_fetch_err;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mest_pro_imem dut (
    .clk            (clk),
    .i_reset_n      (i_reset_n),
    .i_load_start   (i_load_start),
    .i_load_valid   (i_load_valid),
    .i_load_data    (i_load_data),
    .i_load_last    (i_load_last),
    .o_load_ready   (o_load_ready),
    .o_prog_ready   (o_prog_ready),
    .o_prog_len     (o_prog_len),
    .i_req          (i_req),
    .i_prog_counter (i_prog_counter),
    .o_instruction  (o_instruction),
    .o_instr_valid  (o_instr_valid),
    .o_fetch_err    (o_fetch_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fetch(input string tag, input logic [27:0] word, input logic err);
    chk({tag, "_valid"}, 32'(o_instr_valid), 32'd1);
    chk({tag, "_instr"}, 32'(o_instruction), 32'(word));
    chk({tag, "_err"},   32'(o_fetch_err),   32'(err));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_len"},    32'(o_prog_len),    32'd0);
    chk({tag, "_pready"}, 32'(o_prog_ready),  32'd0);
    chk({tag, "_lready"}, 32'(o_load_ready),  32'd0);
    chk({tag, "_valid"},  32'(o_instr_valid), 32'd0);
    chk({tag, "_err"},    32'(o_fetch_err),   32'd0);
    chk({tag, "_instr"},  32'(o_instruction), 32'(FILL));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset_n = 1'b0; i_load_start = 1'b0; i_load_valid = 1'b0; i_load_data = '0;
    i_load_last = 1'b0; i_req = 1'b0; i_prog_counter = '0;
    #1;
    chk_reset_outs("rst");
    step(); step();
    i_reset_n = 1'b1;
    step();

    // 1: fetch with nothing loaded
    i_req = 1'b1; i_prog_counter = 4'd0;
    step();
    chk_fetch("t1_empty", FILL, 1'b1);
    i_req = 1'b0;
    step();
    chk("t1_idle_valid", 32'(o_instr_valid), 32'd0);
    chk("t1_idle_err",   32'(o_fetch_err),   32'd0);

    // 2: three-word program with last on third
    i_load_start = 1'b1; step(); i_load_start = 1'b0;
    chk("t2_lready", 32'(o_load_ready), 32'd1);
    i_load_valid = 1'b1;
    i_load_data = 28'h1000001; step();
    i_load_data = 28'h2000002; step();
    i_load_data = 28'h3000003; i_load_last = 1'b1; step();
    i_load_valid = 1'b0; i_load_last = 1'b0;
    chk("t2_len",    32'(o_prog_len),   32'd3);
    chk("t2_pready", 32'(o_prog_ready), 32'd1);
    chk("t2_lready_done", 32'(o_load_ready), 32'd0);
    i_req = 1'b1; i_prog_counter = 4'd1; step();
    chk_fetch("t2_pc1", 28'h2000002, 1'b0);
    i_prog_counter = 4'd3; step();
    chk_fetch("t2_pc3", FILL, 1'b1);
    i_req = 1'b0; step();
    chk("t2_hold_instr", 32'(o_instruction), 32'(FILL));

    // 3: full 16-word program without last; fetch during load is refused
    i_load_start = 1'b1; step(); i_load_start = 1'b0;
    chk("t3_len_clr", 32'(o_prog_len), 32'd0);
    i_req = 1'b1; i_prog_counter = 4'd0;
    i_load_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      i_load_data = 28'(32'h0ABC000 + i);
      step();
      if (i == 0) chk_fetch("t3_during_load", FILL, 1'b1);
      i_req = 1'b0;
    end
    i_load_valid = 1'b0;
    chk("t3_lready", 32'(o_load_ready), 32'd0);
    chk("t3_len",    32'(o_prog_len),   32'd16);
    chk("t3_pready", 32'(o_prog_ready), 32'd1);
    i_req = 1'b1; i_prog_counter = 4'd15; step();
    chk_fetch("t3_pc15", 28'h0ABC00F, 1'b0);

    // 4: back-to-back fetches
    i_prog_counter = 4'd0; step();
    chk_fetch("t4_pc0", 28'h0ABC000, 1'b0);
    i_prog_counter = 4'd1; step();
    chk_fetch("t4_pc1", 28'h0ABC001, 1'b0);
    i_prog_counter = 4'd2; step();
    chk_fetch("t4_pc2", 28'h0ABC002, 1'b0);
    i_req = 1'b0; step();
    chk("t4_hold_instr", 32'(o_instruction), 32'h0ABC002);

    // 5: start with a word in READY drops the word; then reload two words
    i_load_start = 1'b1; i_load_valid = 1'b1; i_load_data = 28'hDEADBEE; step();
    i_load_start = 1'b0; i_load_valid = 1'b0;
    chk("t5_len",    32'(o_prog_len),   32'd0);
    chk("t5_pready", 32'(o_prog_ready), 32'd0);
    chk("t5_lready", 32'(o_load_ready), 32'd1);
    i_load_valid = 1'b1;
    i_load_data = 28'h1234567; step();
    i_load_data = 28'h7654321; i_load_last = 1'b1; step();
    i_load_valid = 1'b0; i_load_last = 1'b0;
    chk("t5_len2", 32'(o_prog_len), 32'd2);
    i_req = 1'b1; i_prog_counter = 4'd0; step();
    chk_fetch("t5_pc0", 28'h1234567, 1'b0);
    i_prog_counter = 4'd1; step();
    chk_fetch("t5_pc1", 28'h7654321, 1'b0);
    i_prog_counter = 4'd2; step();
    chk_fetch("t5_pc2", FILL, 1'b1);
    i_req = 1'b0; step();

    // 6: reset in the middle of a four-word load
    i_load_start = 1'b1; step(); i_load_start = 1'b0;
    i_load_valid = 1'b1;
    i_load_data = 28'h0000011; step();
    i_load_data = 28'h0000022; step();
    i_load_valid = 1'b0;
    chk("t6_len_mid", 32'(o_prog_len), 32'd2);
    i_reset_n = 1'b0;
    #1;
    chk_reset_outs("t6_rst");
    step();
    i_reset_n = 1'b1;
    step();
    i_req = 1'b1; i_prog_counter = 4'd0; step();
    chk_fetch("t6_pc0", FILL, 1'b1);
    i_req = 1'b0; step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
